// File: rtl/p2s_serializer.sv
// p2s_serializer: parallel-to-serial shifter for 74HC595-style LED chains.
// Define P2S_LATCH_PULSE_EN to add the sr_latch strobe (LATCH state).
module p2s_serializer #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 2,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] par_in,
    output logic              ser_out,
    output logic              sclk,
    output logic              sr_latch,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BC_W  = $clog2(DATA_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef P2S_LATCH_PULSE_EN
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d, sh_nxt;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic              ser_q, ser_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef P2S_LATCH_PULSE_EN
    logic              lat_q, lat_d;
`endif

    function automatic logic head(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    assign sh_nxt = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        div_d   = div_q;
        bit_d   = bit_q;
        ser_d   = ser_q;
        sclk_d  = sclk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef P2S_LATCH_PULSE_EN
        lat_d   = lat_q;
`endif
        unique case (state_q)
            IDLE: begin
                ser_d  = 1'b0;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = SHIFT;
                    sh_d    = par_in;
                    bit_d   = BC_W'(DATA_W);
                    div_d   = '0;
                    busy_d  = 1'b1;
                    ser_d   = head(par_in);
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else if (!sclk_q) begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                end else begin
                    // end of high phase: advance to the next bit
                    div_d  = '0;
                    sclk_d = 1'b0;
                    sh_d   = sh_nxt;
                    bit_d  = bit_q - BC_W'(1);
                    if (bit_q == BC_W'(1)) begin
                        ser_d = 1'b0;
`ifdef P2S_LATCH_PULSE_EN
                        state_d = LATCH;
                        lat_d   = 1'b1;
`else
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        ser_d = head(sh_nxt);
                    end
                end
            end
`ifdef P2S_LATCH_PULSE_EN
            LATCH: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d   = '0;
                    lat_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            ser_q   <= 1'b0;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef P2S_LATCH_PULSE_EN
            lat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ser_q   <= ser_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef P2S_LATCH_PULSE_EN
            lat_q   <= lat_d;
`endif
        end
    end

    assign ser_out = ser_q;
    assign sclk    = sclk_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef P2S_LATCH_PULSE_EN
    assign sr_latch = lat_q;
`else
    assign sr_latch = 1'b0;
`endif

endmodule

// File: tb/tb_p2s_serializer.sv
// Testbench for p2s_serializer: three configurations checked cycle by
// cycle against a per-bit waveform model built from the word.
module tb_p2s_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef P2S_LATCH_PULSE_EN
    localparam int LAT_EN = 1;
`else
    localparam int LAT_EN = 0;
`endif

    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [15:0] par_a = '0, par_c = '0;
    logic [3:0]  par_b = '0;
    logic ser_a, sclk_a, lat_a, busy_a, done_a;
    logic ser_b, sclk_b, lat_b, busy_b, done_b;
    logic ser_c, sclk_c, lat_c, busy_c, done_c;

    int total = 0;
    int bad = 0;
    logic [4:0] cap_q[$];
    logic [4:0] exp_q[$];

    p2s_serializer #(.DATA_W(16), .CLK_DIV(2), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .par_in(par_a),
        .ser_out(ser_a), .sclk(sclk_a), .sr_latch(lat_a),
        .busy(busy_a), .done(done_a));

    p2s_serializer #(.DATA_W(4), .CLK_DIV(1), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .par_in(par_b),
        .ser_out(ser_b), .sclk(sclk_b), .sr_latch(lat_b),
        .busy(busy_b), .done(done_b));

    p2s_serializer #(.DATA_W(16), .CLK_DIV(2), .LSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .par_in(par_c),
        .ser_out(ser_c), .sclk(sclk_c), .sr_latch(lat_c),
        .busy(busy_c), .done(done_c));

    // {ser_out, sclk, sr_latch, busy, done}
    function automatic logic [4:0] outs(input int sel);
        case (sel)
            0:       return {ser_a, sclk_a, lat_a, busy_a, done_a};
            1:       return {ser_b, sclk_b, lat_b, busy_b, done_b};
            default: return {ser_c, sclk_c, lat_c, busy_c, done_c};
        endcase
    endfunction

    task automatic set_start(input int sel, input logic s);
        case (sel)
            0:       start_a = s;
            1:       start_b = s;
            default: start_c = s;
        endcase
    endtask

    task automatic set_par(input int sel, input logic [15:0] w);
        case (sel)
            0:       par_a = w;
            1:       par_b = w[3:0];
            default: par_c = w;
        endcase
    endtask

    // Expected per-cycle outputs starting the cycle after start is accepted
    task automatic build_exp(input logic [15:0] w, input int dw, input int cd,
                             input bit lsb, input bit idle);
        for (int i = 0; i < dw; i++) begin
            logic b;
            b = lsb ? w[i] : w[dw-1-i];
            for (int c = 0; c < 2 * cd; c++)
                exp_q.push_back({b, (c >= cd), 1'b0, 1'b1, 1'b0});
        end
        for (int c = 0; c < cd * LAT_EN; c++)
            exp_q.push_back(5'b00110);
        exp_q.push_back(5'b00001);
        if (idle) exp_q.push_back(5'b00000);
    endtask

    task automatic capture(input int sel, input int n, input bit scramble,
                           input int drop_at);
        cap_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_q.push_back(outs(sel));
            if (scramble) set_par(sel, 16'($urandom()));
            if (i == drop_at) set_start(sel, 1'b0);
        end
    endtask

    task automatic launch(input int sel, input logic [15:0] w);
        @(negedge clk);
        set_par(sel, w);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            total++;
            if (outs(s) !== 5'b0) begin
                bad++;
                $display("FAIL reset dut%0d got=%b want=00000", s, outs(s));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                total++;
                if (outs(s) !== 5'b0) begin
                    bad++;
                    $display("FAIL idle dut%0d cyc=%0d got=%b want=00000",
                             s, i, outs(s));
                end
            end
        end
    endtask

    task automatic test_msb_first;
        logic [15:0] words [2];
        words[0] = 16'hA5C3;
        words[1] = 16'($urandom());
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            build_exp(words[k], 16, 2, 1'b0, 1'b1);
            launch(0, words[k]);
            capture(0, exp_q.size(), 1'b1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (cap_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL msb w=%h cyc=%0d got=%b want=%b",
                             words[k], i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_lsb_first;
        logic [15:0] words [2];
        words[0] = 16'h0001;
        words[1] = 16'($urandom());
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            build_exp(words[k], 16, 2, 1'b1, 1'b1);
            launch(2, words[k]);
            capture(2, exp_q.size(), 1'b1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (cap_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL lsb w=%h cyc=%0d got=%b want=%b",
                             words[k], i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int len;
        len = 16 * 4 + 2 * LAT_EN;
        exp_q.delete();
        build_exp(16'hFFFF, 16, 2, 1'b0, 1'b0);
        build_exp(16'h0000, 16, 2, 1'b0, 1'b1);
        @(negedge clk);
        par_a = 16'hFFFF;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        par_a = 16'h0000;
        capture(0, exp_q.size(), 1'b0, len + 3);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b cyc=%0d got=%b want=%b",
                         i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] w;
        launch(0, 16'($urandom()));
        repeat (20) @(negedge clk);
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy got=%b want=1", busy_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (outs(0) !== 5'b0) begin
            bad++;
            $display("FAIL async_rst got=%b want=00000", outs(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        w = 16'($urandom());
        exp_q.delete();
        build_exp(w, 16, 2, 1'b0, 1'b1);
        launch(0, w);
        capture(0, exp_q.size(), 1'b0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL post_rst w=%h cyc=%0d got=%b want=%b",
                         w, i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clkdiv1;
        logic [15:0] words [2];
        words[0] = 16'h0009;
        words[1] = {12'h0, 4'($urandom())};
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            build_exp(words[k], 4, 1, 1'b0, 1'b1);
            launch(1, words[k]);
            capture(1, exp_q.size(), 1'b1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (cap_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL div1 w=%h cyc=%0d got=%b want=%b",
                             words[k][3:0], i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_msb_first;
        test_lsb_first;
        test_back_to_back;
        test_reset_mid;
        test_clkdiv1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
